seven_segment_scanner: RTL

Time-multiplexed digit scanner for the seven-segment display, directly downstream of the clock divider. It consumes the divider's slow scan clock and its PWM brightness output. It steps one digit per scan-clock rising edge, with a blanking interval between digits to suppress ghosting, and drives active-low anode and cathode lines. Digit data is double-buffered and only committed at frame boundaries, so a frame never shows mixed old and new values.

---
 rtl/seven_segment_scanner.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed seven-segment scanner with blanking between digits and
// frame-aligned double-buffered digit data; all outputs registered (1 cycle).
module seven_segment_scanner #(
  parameter int DIGIT_COUNT = 4,
  parameter int INDEX_WIDTH = 2,
  parameter int BLANK_TICKS = 1,
  parameter int BLANK_WIDTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     scanClock,
  input  logic                     pwm,
  input  logic [4*DIGIT_COUNT-1:0] values,
  input  logic [DIGIT_COUNT-1:0]   decimalPoints,
  input  logic [DIGIT_COUNT-1:0]   digitEnables,
  input  logic                     load,
  output logic                     loadAccepted,
  output logic                     frameStart,
  output logic [DIGIT_COUNT-1:0]   anodes,
  output logic [6:0]               segments,
  output logic                     decimalPoint
);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [INDEX_WIDTH-1:0]   digit_idx_q, digit_idx_d;
  logic [BLANK_WIDTH-1:0]   blank_cnt_q, blank_cnt_d;
  logic                     scan_prev_q, scan_prev_d;

  logic [4*DIGIT_COUNT-1:0] stage_val_q, stage_val_d;
  logic [DIGIT_COUNT-1:0]   stage_dp_q, stage_dp_d;
  logic [DIGIT_COUNT-1:0]   stage_en_q, stage_en_d;
  logic [4*DIGIT_COUNT-1:0] act_val_q, act_val_d;
  logic [DIGIT_COUNT-1:0]   act_dp_q, act_dp_d;
  logic [DIGIT_COUNT-1:0]   act_en_q, act_en_d;
  logic                     pending_q, pending_d;

  logic [DIGIT_COUNT-1:0]   anodes_q, anodes_d;
  logic [6:0]               segments_q, segments_d;
  logic                     dp_q, dp_d;
  logic                     load_acc_q, load_acc_d;
  logic                     frame_start_q, frame_start_d;

  logic                     tick;
  logic                     last_digit;
  logic                     boundary;
  logic                     commit_window;
  logic                     lit;
  logic [3:0]               cur_nibble;
  logic                     cur_dp;

  function automatic logic [6:0] decode(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  always_comb begin
    tick          = scanClock & ~scan_prev_q;
    last_digit    = (digit_idx_q == INDEX_WIDTH'(DIGIT_COUNT - 1));
    boundary      = enable & tick & (state_q == ST_SHOW) & last_digit;
    // While disabled nothing is on screen, so every cycle is a safe commit point.
    commit_window = boundary | ~enable;

    state_d       = state_q;
    digit_idx_d   = digit_idx_q;
    blank_cnt_d   = blank_cnt_q;
    scan_prev_d   = scanClock;

    if (!enable) begin
      state_d     = ST_BLANK;
      digit_idx_d = '0;
      blank_cnt_d = '0;
    end else if (tick) begin
      case (state_q)
        ST_BLANK: begin
          if (blank_cnt_q == BLANK_WIDTH'(BLANK_TICKS - 1)) begin
            state_d     = ST_SHOW;
            blank_cnt_d = '0;
          end else begin
            blank_cnt_d = blank_cnt_q + BLANK_WIDTH'(1);
          end
        end
        default: begin
          state_d     = ST_BLANK;
          digit_idx_d = last_digit ? '0 : digit_idx_q + INDEX_WIDTH'(1);
        end
      endcase
    end

    stage_val_d = stage_val_q;
    stage_dp_d  = stage_dp_q;
    stage_en_d  = stage_en_q;
    act_val_d   = act_val_q;
    act_dp_d    = act_dp_q;
    act_en_d    = act_en_q;
    pending_d   = pending_q;
    load_acc_d  = 1'b0;

    if (load) begin
      stage_val_d = values;
      stage_dp_d  = decimalPoints;
      stage_en_d  = digitEnables;
    end

    if (commit_window && load) begin
      act_val_d  = values;
      act_dp_d   = decimalPoints;
      act_en_d   = digitEnables;
      pending_d  = 1'b0;
      load_acc_d = 1'b1;
    end else if (commit_window && pending_q) begin
      act_val_d  = stage_val_q;
      act_dp_d   = stage_dp_q;
      act_en_d   = stage_en_q;
      pending_d  = 1'b0;
      load_acc_d = 1'b1;
    end else if (load) begin
      pending_d  = 1'b1;
    end

    frame_start_d = boundary;

    cur_nibble = 4'h0;
    cur_dp     = 1'b0;
    for (int i = 0; i < DIGIT_COUNT; i++) begin
      if (digit_idx_q == INDEX_WIDTH'(i)) begin
        cur_nibble = act_val_q[4*i +: 4];
        cur_dp     = act_dp_q[i];
      end
    end

    lit = (state_q == ST_SHOW) & enable & pwm & act_en_q[digit_idx_q];

    if (lit) begin
      anodes_d   = ~(DIGIT_COUNT'(1) << digit_idx_q);
      segments_d = decode(cur_nibble);
      dp_d       = ~cur_dp;
    end else begin
      anodes_d   = '1;
      segments_d = 7'h7F;
      dp_d       = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_BLANK;
      digit_idx_q   <= '0;
      blank_cnt_q   <= '0;
      scan_prev_q   <= 1'b0;
      stage_val_q   <= '0;
      stage_dp_q    <= '0;
      stage_en_q    <= '0;
      act_val_q     <= '0;
      act_dp_q      <= '0;
      act_en_q      <= '0;
      pending_q     <= 1'b0;
      anodes_q      <= '1;
      segments_q    <= 7'h7F;
      dp_q          <= 1'b1;
      load_acc_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      digit_idx_q   <= digit_idx_d;
      blank_cnt_q   <= blank_cnt_d;
      scan_prev_q   <= scan_prev_d;
      stage_val_q   <= stage_val_d;
      stage_dp_q    <= stage_dp_d;
      stage_en_q    <= stage_en_d;
      act_val_q     <= act_val_d;
      act_dp_q      <= act_dp_d;
      act_en_q      <= act_en_d;
      pending_q     <= pending_d;
      anodes_q      <= anodes_d;
      segments_q    <= segments_d;
      dp_q          <= dp_d;
      load_acc_q    <= load_acc_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign anodes       = anodes_q;
  assign segments     = segments_q;
  assign decimalPoint = dp_q;
  assign loadAccepted = load_acc_q;
  assign frameStart   = frame_start_q;

endmodule
